// File: rtl/conv_pkg.sv
// Shared types and geometry helpers for the sliding-window convolution input buffer.
package conv_pkg;

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // Counter width for a count range of n (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Number of window positions along one axis.
    function automatic int unsigned out_dim(input int unsigned size, input int unsigned k,
                                            input int unsigned stride);
        return (size - k) / stride + 1;
    endfunction

    // Flat window element index: channel-major, then row (oldest first), then column.
    function automatic int unsigned win_idx(input int unsigned c, input int unsigned ky,
                                            input int unsigned kx, input int unsigned k);
        return (c * k + ky) * k + kx;
    endfunction

endpackage

// File: rtl/conv_line_mem.sv
// One channel of the (K-1) x WIDTH circular row store; reads one column of all stored rows.
module conv_line_mem
    import conv_pkg::*;
#(
    parameter  int unsigned WIDTH     = 28,
    parameter  int unsigned K         = 5,
    parameter  int unsigned DATA_BITS = 8,
    localparam int unsigned CW        = cnt_w(WIDTH),
    localparam int unsigned PW        = cnt_w(K - 1)
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [PW-1:0]                row_ptr,
    input  logic [CW-1:0]                col,
    input  logic [DATA_BITS-1:0]         din,
    output logic [(K-1)*DATA_BITS-1:0]   col_out
);

    logic [DATA_BITS-1:0] row_mem [K-1][WIDTH];

    // Write the new pixel over the oldest stored row at this column.
    always_ff @(posedge clk) begin
        if (we) begin
            row_mem[row_ptr][col] <= din;
        end
    end

    // Column read, oldest row first; the oldest row lives at row_ptr.
    always_comb begin
        int unsigned slot;
        slot    = 0;
        col_out = '0;
        for (int unsigned i = 0; i < K - 1; i++) begin
            slot = 32'(row_ptr) + i;
            if (slot >= K - 1) begin
                slot = slot - (K - 1);
            end
            col_out[i*DATA_BITS +: DATA_BITS] = row_mem[PW'(slot)][col];
        end
    end

endmodule

// File: rtl/conv_window_buf.sv
// Sliding KxK window buffer over a raster pixel stream, all channels in parallel.
// Optional downstream backpressure: define CONV_BUF_BACKPRESSURE_EN.
module conv_window_buf
    import conv_pkg::*;
#(
    parameter int unsigned WIDTH     = 28,
    parameter int unsigned HEIGHT    = 28,
    parameter int unsigned K         = 5,
    parameter int unsigned STRIDE    = 1,
    parameter int unsigned CHANNELS  = 1,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                valid_in,
    input  logic [CHANNELS*DATA_BITS-1:0]       data_in,
`ifdef CONV_BUF_BACKPRESSURE_EN
    output logic                                ready_in,
    input  logic                                ready_out,
`endif
    output logic [CHANNELS*K*K*DATA_BITS-1:0]   data_out,
    output logic                                valid_out,
    output logic                                frame_done
);

    localparam int unsigned CW       = cnt_w(WIDTH);
    localparam int unsigned RW       = cnt_w(HEIGHT);
    localparam int unsigned PW       = cnt_w(K - 1);
    localparam int unsigned SW       = cnt_w(STRIDE);
    localparam int unsigned OUT_W    = out_dim(WIDTH, K, STRIDE);
    localparam int unsigned OUT_H    = out_dim(HEIGHT, K, STRIDE);
    localparam int unsigned LAST_X   = K - 1 + (OUT_W - 1) * STRIDE;
    localparam int unsigned LAST_Y   = K - 1 + (OUT_H - 1) * STRIDE;
    localparam int unsigned OUT_BITS = CHANNELS * K * K * DATA_BITS;

    state_e                      state_q, state_d;
    logic [CW-1:0]               col_q, col_d;
    logic [RW-1:0]               row_q, row_d;
    logic [PW-1:0]               ptr_q, ptr_d;
    logic [SW-1:0]               xph_q, xph_d;
    logic [SW-1:0]               yph_q, yph_d;
    logic [OUT_BITS-1:0]         win_q, win_d;
    logic [OUT_BITS-1:0]         data_out_q, data_out_d;
    logic                        valid_out_q, valid_out_d;
    logic                        frame_done_q, frame_done_d;
    logic                        ready_c;
    logic                        accept_c;
    logic                        win_ready_c;
    logic [(K-1)*DATA_BITS-1:0]  mem_col [CHANNELS];

`ifdef CONV_BUF_BACKPRESSURE_EN
    assign ready_c  = !valid_out_q || ready_out;
    assign ready_in = ready_c;
`else
    assign ready_c  = 1'b1;
`endif

    assign accept_c   = valid_in && ready_c;
    assign data_out   = data_out_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_mem
        conv_line_mem #(
            .WIDTH     (WIDTH),
            .K         (K),
            .DATA_BITS (DATA_BITS)
        ) u_line_mem (
            .clk     (clk),
            .we      (accept_c),
            .row_ptr (ptr_q),
            .col     (col_q),
            .din     (data_in[ch*DATA_BITS +: DATA_BITS]),
            .col_out (mem_col[ch])
        );
    end

    // Next-state: raster counters, stride phases, window shift and output register.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        ptr_d        = ptr_q;
        xph_d        = xph_q;
        yph_d        = yph_q;
        win_d        = win_q;
        data_out_d   = data_out_q;
        valid_out_d  = valid_out_q;
        frame_done_d = frame_done_q;
        win_ready_c  = 1'b0;

        // A taken (or never-held) window retires unless replaced below.
        if (ready_c) begin
            valid_out_d  = 1'b0;
            frame_done_d = 1'b0;
        end

        if (accept_c) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                for (int unsigned ky = 0; ky < K; ky++) begin
                    for (int unsigned kx = 0; kx < K; kx++) begin
                        if (kx < K - 1) begin
                            win_d[win_idx(c, ky, kx, K)*DATA_BITS +: DATA_BITS] =
                                win_q[win_idx(c, ky, kx + 1, K)*DATA_BITS +: DATA_BITS];
                        end else if (ky < K - 1) begin
                            win_d[win_idx(c, ky, kx, K)*DATA_BITS +: DATA_BITS] =
                                mem_col[c][ky*DATA_BITS +: DATA_BITS];
                        end else begin
                            win_d[win_idx(c, ky, kx, K)*DATA_BITS +: DATA_BITS] =
                                data_in[c*DATA_BITS +: DATA_BITS];
                        end
                    end
                end
            end

            win_ready_c = (state_q == STREAM) && (col_q >= CW'(K - 1)) &&
                          (xph_q == '0) && (yph_q == '0);
            if (win_ready_c) begin
                data_out_d   = win_d;
                valid_out_d  = 1'b1;
                frame_done_d = (row_q == RW'(LAST_Y)) && (col_q == CW'(LAST_X));
            end

            if (col_q >= CW'(K - 1)) begin
                xph_d = (xph_q == SW'(STRIDE - 1)) ? '0 : xph_q + SW'(1);
            end

            if (col_q == CW'(WIDTH - 1)) begin
                col_d = '0;
                xph_d = '0;
                if (row_q == RW'(HEIGHT - 1)) begin
                    row_d   = '0;
                    ptr_d   = '0;
                    yph_d   = '0;
                    state_d = FILL;
                end else begin
                    row_d = row_q + RW'(1);
                    ptr_d = (ptr_q == PW'(K - 2)) ? '0 : ptr_q + PW'(1);
                    if (state_q == STREAM) begin
                        yph_d = (yph_q == SW'(STRIDE - 1)) ? '0 : yph_q + SW'(1);
                    end
                    if (row_q == RW'(K - 2)) begin
                        state_d = STREAM;
                    end
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= FILL;
            col_q        <= '0;
            row_q        <= '0;
            ptr_q        <= '0;
            xph_q        <= '0;
            yph_q        <= '0;
            data_out_q   <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            ptr_q        <= ptr_d;
            xph_q        <= xph_d;
            yph_q        <= yph_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Window history is pure datapath; only flagged positions ever reach the output.
    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

endmodule
